// File: rtl/tt_um_jimktrains_vslc_capture.sv
// Pulse-width capture: measures high/low durations of capture_in in timer_clk ticks,
// reporting N for a level lasting N+1 ticks (same encoding as the VSLC timer periods).
module tt_um_jimktrains_vslc_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             timer_clk,
  input  logic             capture_in,
  input  logic             capture_enabled,
  output logic [CNT_W-1:0] measured_high,
  output logic [CNT_W-1:0] measured_low,
  output logic             high_valid,
  output logic             low_valid,
  output logic             pair_valid,
  output logic             overflow
);

  typedef enum logic [1:0] {
    ARM       = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W:0] CNT_ONE = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W:0] CNT_MAX = {1'b1, {CNT_W{1'b0}}};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_prev_q;
  logic                   timer_clk_prev_q;
  logic                   s_in;
  logic                   rise;
  logic                   fall;
  logic                   tick;

  state_t                 state_q;
  logic [CNT_W:0]         cnt_q;
  logic                   sat_q;
  logic                   have_high_q;
  logic [CNT_W:0]         cnt_m1;
  logic [CNT_W-1:0]       report_d;

  // Synchronizer and tick edge detect run freely, even through reset/disable.
  always_ff @(posedge clk) begin
    sync_q           <= {sync_q[SYNC_STAGES-2:0], capture_in};
    s_prev_q         <= s_in;
    timer_clk_prev_q <= timer_clk;
  end

  assign s_in = sync_q[SYNC_STAGES-1];
  assign rise = s_in & ~s_prev_q;
  assign fall = ~s_in & s_prev_q;
  assign tick = timer_clk & ~timer_clk_prev_q;

  assign cnt_m1 = cnt_q - CNT_ONE;

  // A glitch with no ticks reports 0; a saturated level pins to all-ones.
  always_comb begin
    report_d = '0;
    if (sat_q) begin
      report_d = '1;
    end else if (cnt_q != '0) begin
      report_d = cnt_m1[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !capture_enabled) begin
      state_q       <= ARM;
      cnt_q         <= '0;
      sat_q         <= 1'b0;
      have_high_q   <= 1'b0;
      measured_high <= '0;
      measured_low  <= '0;
      high_valid    <= 1'b0;
      low_valid     <= 1'b0;
      pair_valid    <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      high_valid <= 1'b0;
      low_valid  <= 1'b0;
      pair_valid <= 1'b0;
      if (state_q == ARM) begin
        have_high_q <= 1'b0;
      end
      if (rise || fall) begin
        // A tick coincident with the edge is credited to the new level.
        cnt_q <= tick ? CNT_ONE : '0;
        sat_q <= 1'b0;
        case (state_q)
          ARM: begin
            state_q <= rise ? MEAS_HIGH : MEAS_LOW;
          end
          MEAS_HIGH: begin
            if (fall) begin
              measured_high <= report_d;
              high_valid    <= 1'b1;
              have_high_q   <= 1'b1;
              overflow      <= overflow | sat_q;
              state_q       <= MEAS_LOW;
            end
          end
          MEAS_LOW: begin
            if (rise) begin
              measured_low <= report_d;
              low_valid    <= 1'b1;
              pair_valid   <= have_high_q;
              overflow     <= overflow | sat_q;
              state_q      <= MEAS_HIGH;
            end
          end
          default: begin
            state_q <= ARM;
          end
        endcase
      end else if (tick) begin
        if (cnt_q == CNT_MAX) begin
          sat_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_capture.sv
// Bench for the pulse-width capture unit: directed scenarios plus random levels,
// every cycle compared against a tick-counting reference model.
module tb_tt_um_jimktrains_vslc_capture;

  localparam int S    = 2;
  localparam int W    = 8;
  localparam int MAXC = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         timer_clk;
  logic         capture_in;
  logic         capture_enabled;
  logic [W-1:0] measured_high;
  logic [W-1:0] measured_low;
  logic         high_valid;
  logic         low_valid;
  logic         pair_valid;
  logic         overflow;

  tt_um_jimktrains_vslc_capture #(.SYNC_STAGES(S), .CNT_W(W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .timer_clk       (timer_clk),
    .capture_in      (capture_in),
    .capture_enabled (capture_enabled),
    .measured_high   (measured_high),
    .measured_low    (measured_low),
    .high_valid      (high_valid),
    .low_valid       (low_valid),
    .pair_valid      (pair_valid),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   tp    = 4;
  int   phase = 0;
  logic rn_drv = 1'b0;
  logic en_drv = 1'b1;
  logic cur    = 1'b0;
  logic tclk_last = 1'b0;
  logic cq[$];

  // Reference model: an unbounded tick count per level, reported by rule.
  bit   m_armed = 0;
  bit   m_hh    = 0;
  int   m_cnt   = 0;
  int   m_mh = 0, m_ml = 0;
  bit   m_hv = 0, m_lv = 0, m_pv = 0, m_ovf = 0;

  int   n_hv = 0, n_lv = 0, n_pv = 0;
  int   last_mh = 0, last_ml = 0;

  function automatic int rep(input int c);
    if (c == 0) return 0;
    if (c > MAXC) return MAXC - 1;
    return c - 1;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic cin);
    logic tk, s_in_m, s_prev_m, rise, fall;
    timer_clk       = ((phase % tp) == 0);
    capture_in      = cin;
    rst_n           = rn_drv;
    capture_enabled = en_drv;
    cq.push_back(cin);
    if (cq.size() > S + 2) void'(cq.pop_front());
    @(posedge clk);
    phase++;
    tk        = timer_clk && !tclk_last;
    tclk_last = timer_clk;
    s_in_m    = cq[cq.size() - 1 - S];
    s_prev_m  = cq[cq.size() - 2 - S];
    rise      = s_in_m && !s_prev_m;
    fall      = !s_in_m && s_prev_m;
    if (!rn_drv || !en_drv) begin
      m_armed = 0; m_hh = 0; m_cnt = 0; m_mh = 0; m_ml = 0;
      m_hv = 0; m_lv = 0; m_pv = 0; m_ovf = 0;
    end else begin
      m_hv = 0; m_lv = 0; m_pv = 0;
      if (rise || fall) begin
        if (m_armed && fall) begin
          m_mh = rep(m_cnt); m_hv = 1; m_hh = 1;
          if (m_cnt > MAXC) m_ovf = 1;
        end
        if (m_armed && rise) begin
          m_ml = rep(m_cnt); m_lv = 1; m_pv = m_hh;
          if (m_cnt > MAXC) m_ovf = 1;
        end
        m_armed = 1;
        m_cnt   = tk ? 1 : 0;
      end else if (tk) begin
        m_cnt++;
      end
    end
    @(negedge clk);
    chk("measured_high", int'(measured_high), m_mh);
    chk("measured_low",  int'(measured_low),  m_ml);
    chk("high_valid",    int'(high_valid),    int'(m_hv));
    chk("low_valid",     int'(low_valid),     int'(m_lv));
    chk("pair_valid",    int'(pair_valid),    int'(m_pv));
    chk("overflow",      int'(overflow),      int'(m_ovf));
    if (high_valid) begin n_hv++; last_mh = int'(measured_high); end
    if (low_valid)  begin n_lv++; last_ml = int'(measured_low);  end
    if (pair_valid) n_pv++;
  endtask

  task automatic hold(input logic v, input int n);
    cur = v;
    for (int i = 0; i < n; i++) step(v);
  endtask

  task automatic align(input int p);
    for (int i = 0; i < tp && (phase % tp) != p; i++) step(cur);
  endtask

  initial begin
    int base_hv, base_pv, len, dis;
    logic lv;
    for (int i = 0; i < S + 2; i++) cq.push_back(1'b0);
    timer_clk = 1'b0; capture_in = 1'b0; rst_n = 1'b0; capture_enabled = 1'b1;
    @(negedge clk);

    hold(1'b0, 8);
    chk("rst_mh", int'(measured_high), 0);
    chk("rst_ml", int'(measured_low), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_valids", int'({high_valid, low_valid, pair_valid}), 0);
    rn_drv = 1'b1;

    // Basic: high 6 ticks, low 3 ticks; first rise only arms.
    tp = 4; align(1);
    hold(1'b0, 6 * tp);
    hold(1'b1, 6 * tp);
    chk("basic_arm_no_hv", n_hv, 0);
    hold(1'b0, 3 * tp);
    chk("basic_mh", last_mh, 5);
    chk("basic_hv_cnt", n_hv, 1);
    hold(1'b1, 2 * tp);
    chk("basic_ml", last_ml, 2);
    chk("basic_pv_cnt", n_pv, 1);
    chk("basic_ovf", int'(overflow), 0);

    // Timer-style loopback waveform: low 11 ticks, high 21 ticks.
    align(1);
    base_pv = n_pv;
    for (int i = 0; i < 7; i++) begin
      hold(1'b0, 11 * tp);
      if (i >= 1) chk("loop_mh", last_mh, 20);
      hold(1'b1, 21 * tp);
      if (i >= 1) chk("loop_ml", last_ml, 10);
    end
    chk("loop_pv_cnt", n_pv - base_pv, 7);

    // Overflow: 300-tick high saturates, following 4-tick low is exact.
    tp = 2; align(1);
    hold(1'b0, 2 * tp);
    hold(1'b1, 300 * tp);
    hold(1'b0, 4 * tp);
    chk("ovf_mh", last_mh, 255);
    chk("ovf_flag", int'(overflow), 1);
    hold(1'b1, 2 * tp);
    chk("ovf_ml", last_ml, 3);
    chk("ovf_sticky", int'(overflow), 1);

    // Glitch shorter than a tick between two lows.
    tp = 8; align(1);
    hold(1'b0, 3 * tp);
    base_hv = n_hv;
    hold(1'b1, 3);
    chk("glitch_ml_before", last_ml, 2);
    hold(1'b0, 5);
    chk("glitch_mh", last_mh, 0);
    chk("glitch_hv", n_hv - base_hv, 1);
    hold(1'b0, 4 * tp);
    hold(1'b1, 2 * tp);
    chk("glitch_ml_after", last_ml, 4);

    // Rise coincident with a tick: 5-tick low, 7-tick high including that tick.
    tp = 4; align(1);
    hold(1'b0, 5 * tp + 1);
    hold(1'b1, 25);
    chk("bnd_ml", last_ml, 4);
    hold(1'b0, 2 * tp);
    chk("bnd_mh", last_mh, 6);

    // Reset for one clk while measuring a high.
    align(1);
    hold(1'b1, 3 * tp);
    rn_drv = 1'b0; step(1'b1); rn_drv = 1'b1;
    chk("rst_mid_mh", int'(measured_high), 0);
    chk("rst_mid_ml", int'(measured_low), 0);
    chk("rst_mid_ovf", int'(overflow), 0);
    base_hv = n_hv;
    hold(1'b1, 2 * tp);
    hold(1'b0, 3 * tp);
    chk("rst_mid_fall_unreported", n_hv - base_hv, 0);
    hold(1'b1, 2 * tp);

    // Disable for 2 clks after an overflow.
    tp = 2; align(1);
    hold(1'b0, 2 * tp);
    hold(1'b1, 260 * tp);
    hold(1'b0, 2 * tp);
    chk("dis_ovf_set", int'(overflow), 1);
    hold(1'b1, 3 * tp);
    en_drv = 1'b0; step(1'b1); step(1'b1); en_drv = 1'b1;
    chk("dis_ovf_clr", int'(overflow), 0);
    chk("dis_mh", int'(measured_high), 0);
    chk("dis_ml", int'(measured_low), 0);
    base_hv = n_hv;
    hold(1'b1, tp);
    hold(1'b0, 3 * tp);
    chk("dis_fall_unreported", n_hv - base_hv, 0);

    // Random levels, tick spacings and occasional disables.
    lv = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tp  = int'($urandom_range(2, 6));
      len = ($urandom_range(0, 19) == 0) ? int'($urandom_range(520, 700))
                                          : int'($urandom_range(1, 60));
      hold(lv, len);
      if ($urandom_range(0, 24) == 0) begin
        dis = int'($urandom_range(1, 3));
        en_drv = 1'b0;
        for (int k = 0; k < dis; k++) step(lv);
        en_drv = 1'b1;
      end
      lv = ~lv;
    end
    hold(lv, 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
